// File: rtl/ppl_ctrl_if.sv
// Signal bundle between ppl_ctrl and the IF, ID/EX hazard logic and the interrupt line.
interface ppl_ctrl_if;
    logic        hold_pc_i;
    logic [15:0] if_pc_i;
    logic        ex_resolve_i;
    logic        ex_jump_i;
    logic [15:0] ex_jump_pc_i;
    logic        load_hazard_i;
    logic        irq_i;
    logic        int_ret_i;
    logic        jump_flag;
    logic [15:0] jump_pc;
    logic [1:0]  hold_flag;
    logic        flush_o;
    logic        int_active;
    logic [15:0] epc;
    logic        err_o;

    modport master (
        output hold_pc_i, if_pc_i, ex_resolve_i, ex_jump_i, ex_jump_pc_i,
               load_hazard_i, irq_i, int_ret_i,
        input  jump_flag, jump_pc, hold_flag, flush_o, int_active, epc, err_o
    );

    modport slave (
        input  hold_pc_i, if_pc_i, ex_resolve_i, ex_jump_i, ex_jump_pc_i,
               load_hazard_i, irq_i, int_ret_i,
        output jump_flag, jump_pc, hold_flag, flush_o, int_active, epc, err_o
    );
endinterface

// File: rtl/ppl_ctrl.sv
// Pipeline control: branch hold/redirect, load-use stall and interrupt entry/return for IF.
// Interrupt sequencing (in_isr/epc) is built only when PPL_CTRL_INT_EN is defined.
module ppl_ctrl #(
    parameter logic [15:0] INT_VECTOR = 16'h0010,
    parameter int          MAX_WAIT   = 4
) (
    input logic       clk,
    input logic       rst_n,
    ppl_ctrl_if.slave bus
);
    typedef enum logic {IDLE, BR_WAIT} state_t;

    localparam logic [1:0] HOLD_NONE = 2'b00;
    localparam logic [1:0] HOLD_PC   = 2'b01;
    localparam logic [1:0] HOLD_PPL  = 2'b11;
    localparam logic [2:0] WCNT_LAST = 3'(MAX_WAIT - 1);

    state_t      state, state_nxt;
    logic [2:0]  wcnt, wcnt_nxt;
    logic        ready;
    logic        active;
    logic        ret_req;
    logic        entry_req;
    logic [15:0] epc_val;
    logic        jump_flag;
    logic [15:0] jump_pc;
    logic [1:0]  hold_flag;
    logic        flush;
    logic        err;

    // ready stays low for the cycle after reset so every output is quiet there too
    assign active = rst_n & ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            wcnt  <= '0;
            ready <= 1'b0;
        end else begin
            ready <= 1'b1;
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        jump_flag = 1'b0;
        jump_pc   = '0;
        hold_flag = HOLD_NONE;
        flush     = 1'b0;
        err       = 1'b0;
        if (active) begin
            case (state)
                IDLE: begin
                    if (ret_req) begin
                        jump_flag = 1'b1;
                        jump_pc   = epc_val;
                        flush     = 1'b1;
                    end else if (entry_req) begin
                        jump_flag = 1'b1;
                        jump_pc   = INT_VECTOR;
                        flush     = 1'b1;
                    end else if (bus.load_hazard_i) begin
                        hold_flag = HOLD_PPL;
                    end else if (bus.hold_pc_i) begin
                        hold_flag = HOLD_PC;
                        state_nxt = BR_WAIT;
                        wcnt_nxt  = '0;
                    end
                end
                BR_WAIT: begin
                    hold_flag = HOLD_PC;
                    // a taken branch keeps the PC held in its resolve cycle; IF loads jump_pc instead
                    if (bus.ex_resolve_i) begin
                        state_nxt = IDLE;
                        if (bus.ex_jump_i) begin
                            jump_flag = 1'b1;
                            jump_pc   = bus.ex_jump_pc_i;
                            flush     = 1'b1;
                        end else begin
                            hold_flag = HOLD_NONE;
                        end
                    end else if (wcnt == WCNT_LAST) begin
                        err       = 1'b1;
                        hold_flag = HOLD_NONE;
                        state_nxt = IDLE;
                    end else begin
                        wcnt_nxt = wcnt + 3'd1;
                    end
                end
            endcase
        end
    end

`ifdef PPL_CTRL_INT_EN
    logic        in_isr;
    logic [15:0] epc_q;

    // a pending branch or hazard in IF/ID defers entry; a return always beats a new request
    assign ret_req   = in_isr & bus.int_ret_i;
    assign entry_req = bus.irq_i & ~in_isr & ~bus.hold_pc_i & ~bus.load_hazard_i;
    assign epc_val   = epc_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_isr <= 1'b0;
            epc_q  <= '0;
        end else if (ready && state == IDLE) begin
            if (ret_req) begin
                in_isr <= 1'b0;
            end else if (entry_req) begin
                in_isr <= 1'b1;
                epc_q  <= bus.if_pc_i;
            end
        end
    end

    assign bus.int_active = in_isr;
    assign bus.epc        = epc_q;
`else
    logic unused_int;

    assign ret_req        = 1'b0;
    assign entry_req      = 1'b0;
    assign epc_val        = '0;
    assign unused_int     = ^{bus.irq_i, bus.int_ret_i, bus.if_pc_i};
    assign bus.int_active = 1'b0;
    assign bus.epc        = '0;
`endif

    assign bus.jump_flag = jump_flag;
    assign bus.jump_pc   = jump_pc;
    assign bus.hold_flag = hold_flag;
    assign bus.flush_o   = flush;
    assign bus.err_o     = err;
endmodule

// File: tb/tb_ppl_ctrl.sv
// Self-checking bench for ppl_ctrl: directed scenarios plus randomized traffic against a reference model.
module tb_ppl_ctrl;
    localparam logic [15:0] VEC  = 16'h0010;
    localparam int          MAXW = 4;
`ifdef PPL_CTRL_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_compared = 0;
    int   n_mismatch = 0;

    ppl_ctrl_if bus();

    ppl_ctrl #(.INT_VECTOR(VEC), .MAX_WAIT(MAXW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // observed words: {jump_flag, jump_pc, hold_flag, flush_o, err_o} and {int_active, epc}
    logic [20:0] obs_comb;
    logic [16:0] obs_reg;
    assign obs_comb = {bus.jump_flag, bus.jump_pc, bus.hold_flag, bus.flush_o, bus.err_o};
    assign obs_reg  = {bus.int_active, bus.epc};

    bit          s_rst_n, s_hold, s_res, s_jmp, s_haz, s_irq, s_ret;
    logic [15:0] s_pc, s_jpc;

    // reference model: a branch is "pending" for up to MAXW waiting cycles; ISR is a flag plus saved PC
    bit          m_fresh, m_pending, m_isr;
    int          m_waited;
    logic [15:0] m_epc = '0;
    bit          n_fresh, n_pending, n_isr;
    int          n_waited;
    logic [15:0] n_epc = '0;
    logic [20:0] e_comb;

    function automatic logic [20:0] word(bit jf, logic [15:0] pc, logic [1:0] hold, bit fl, bit er);
        return {jf, pc, hold, fl, er};
    endfunction

    task automatic model_eval();
        e_comb    = '0;
        n_fresh   = m_fresh;
        n_pending = m_pending;
        n_waited  = m_waited;
        n_isr     = m_isr;
        n_epc     = m_epc;
        if (!s_rst_n) begin
            n_fresh = 1; n_pending = 0; n_waited = 0; n_isr = 0; n_epc = '0;
        end else if (m_fresh) begin
            n_fresh = 0;
        end else if (m_pending) begin
            if (s_res) begin
                n_pending = 0;
                if (s_jmp) e_comb = word(1, s_jpc, 2'b01, 1, 0);
            end else if (m_waited + 1 == MAXW) begin
                n_pending = 0;
                e_comb    = word(0, 16'h0, 2'b00, 0, 1);
            end else begin
                n_waited = m_waited + 1;
                e_comb   = word(0, 16'h0, 2'b01, 0, 0);
            end
        end else if (INT_EN && s_ret && m_isr) begin
            n_isr  = 0;
            e_comb = word(1, m_epc, 2'b00, 1, 0);
        end else if (INT_EN && s_irq && !m_isr && !s_hold && !s_haz) begin
            n_isr  = 1;
            n_epc  = s_pc;
            e_comb = word(1, VEC, 2'b00, 1, 0);
        end else if (s_haz) begin
            e_comb = word(0, 16'h0, 2'b11, 0, 0);
        end else if (s_hold) begin
            n_pending = 1;
            n_waited  = 0;
            e_comb    = word(0, 16'h0, 2'b01, 0, 0);
        end
    endtask

    always @(posedge clk) begin
        m_fresh   <= n_fresh;
        m_pending <= n_pending;
        m_waited  <= n_waited;
        m_isr     <= n_isr;
        m_epc     <= n_epc;
    end

    task automatic clear_stim();
        s_rst_n = 1; s_hold = 0; s_res = 0; s_jmp = 0; s_haz = 0; s_irq = 0; s_ret = 0;
        s_pc = 16'h0100; s_jpc = 16'h0000;
    endtask

    // one clock cycle: drive on the falling edge, outputs settle 1 unit later
    task automatic step();
        @(negedge clk);
        rst_n             = s_rst_n;
        bus.hold_pc_i     = s_hold;
        bus.if_pc_i       = s_pc;
        bus.ex_resolve_i  = s_res;
        bus.ex_jump_i     = s_jmp;
        bus.ex_jump_pc_i  = s_jpc;
        bus.load_hazard_i = s_haz;
        bus.irq_i         = s_irq;
        bus.int_ret_i     = s_ret;
        model_eval();
        #1;
    endtask

    task automatic test_reset();
        clear_stim();
        s_rst_n = 0; s_hold = 1; s_irq = 1; s_haz = 1; s_res = 1; s_jmp = 1; s_jpc = 16'hBEEF;
        step();
        step();
        n_compared++;
        if (obs_comb !== 21'h0) begin
            n_mismatch++; $display("[TB] FAIL reset_comb: got %h want %h", obs_comb, 21'h0);
        end
        n_compared++;
        if (obs_reg !== 17'h0) begin
            n_mismatch++; $display("[TB] FAIL reset_reg: got %h want %h", obs_reg, 17'h0);
        end
        s_rst_n = 1;
        step();
        n_compared++;
        if (obs_comb !== 21'h0) begin
            n_mismatch++; $display("[TB] FAIL reset_after_comb: got %h want %h", obs_comb, 21'h0);
        end
        clear_stim();
        step();
        n_compared++;
        if (obs_comb !== 21'h0) begin
            n_mismatch++; $display("[TB] FAIL reset_idle_comb: got %h want %h", obs_comb, 21'h0);
        end
    endtask

    task automatic test_branch(input bit taken);
        logic [20:0] want;
        clear_stim();
        s_hold = 1; step();
        want = word(0, 16'h0, 2'b01, 0, 0);
        n_compared++;
        if (obs_comb !== want) begin
            n_mismatch++; $display("[TB] FAIL branch_c10 taken=%0d: got %h want %h", taken, obs_comb, want);
        end
        s_hold = 0; step();
        n_compared++;
        if (obs_comb !== want) begin
            n_mismatch++; $display("[TB] FAIL branch_c11 taken=%0d: got %h want %h", taken, obs_comb, want);
        end
        s_res = 1; s_jmp = taken; s_jpc = 16'h0040; step();
        want = taken ? word(1, 16'h0040, 2'b01, 1, 0) : word(0, 16'h0, 2'b00, 0, 0);
        n_compared++;
        if (obs_comb !== want) begin
            n_mismatch++; $display("[TB] FAIL branch_c12 taken=%0d: got %h want %h", taken, obs_comb, want);
        end
        clear_stim(); step();
        n_compared++;
        if (obs_comb !== 21'h0) begin
            n_mismatch++; $display("[TB] FAIL branch_after taken=%0d: got %h want %h", taken, obs_comb, 21'h0);
        end
    endtask

    task automatic test_timeout();
        logic [20:0] want;
        clear_stim();
        s_hold = 1; step();
        s_hold = 0;
        for (int i = 1; i <= MAXW; i++) begin
            step();
            want = (i == MAXW) ? word(0, 16'h0, 2'b00, 0, 1) : word(0, 16'h0, 2'b01, 0, 0);
            n_compared++;
            if (obs_comb !== want) begin
                n_mismatch++; $display("[TB] FAIL timeout_wait%0d: got %h want %h", i, obs_comb, want);
            end
        end
        step();
        n_compared++;
        if (obs_comb !== 21'h0) begin
            n_mismatch++; $display("[TB] FAIL timeout_idle: got %h want %h", obs_comb, 21'h0);
        end
    endtask

    task automatic test_load_hazard();
        logic [20:0] want;
        clear_stim();
        s_haz = 1; s_irq = 1; s_pc = 16'h0044; step();
        want = word(0, 16'h0, 2'b11, 0, 0);
        n_compared++;
        if (obs_comb !== want) begin
            n_mismatch++; $display("[TB] FAIL hazard_cycle: got %h want %h", obs_comb, want);
        end
        clear_stim(); step();
        n_compared++;
        if (obs_comb !== 21'h0) begin
            n_mismatch++; $display("[TB] FAIL hazard_release: got %h want %h", obs_comb, 21'h0);
        end
        n_compared++;
        if (obs_reg !== 17'h0) begin
            n_mismatch++; $display("[TB] FAIL hazard_no_entry: got %h want %h", obs_reg, 17'h0);
        end
    endtask

    task automatic test_interrupt();
        logic [20:0] want;
        logic [16:0] want_reg;
        clear_stim();
        s_irq = 1; s_pc = 16'h0023; step();
        want = INT_EN ? word(1, VEC, 2'b00, 1, 0) : 21'h0;
        n_compared++;
        if (obs_comb !== want) begin
            n_mismatch++; $display("[TB] FAIL int_entry: got %h want %h", obs_comb, want);
        end
        s_pc = 16'h0055; step();
        want_reg = INT_EN ? {1'b1, 16'h0023} : 17'h0;
        n_compared++;
        if (obs_reg !== want_reg) begin
            n_mismatch++; $display("[TB] FAIL int_epc_saved: got %h want %h", obs_reg, want_reg);
        end
        n_compared++;
        if (obs_comb !== 21'h0) begin
            n_mismatch++; $display("[TB] FAIL int_no_nesting: got %h want %h", obs_comb, 21'h0);
        end
        s_ret = 1; step();
        want = INT_EN ? word(1, 16'h0023, 2'b00, 1, 0) : 21'h0;
        n_compared++;
        if (obs_comb !== want) begin
            n_mismatch++; $display("[TB] FAIL int_return: got %h want %h", obs_comb, want);
        end
        s_ret = 0; s_pc = 16'h0031; step();
        want_reg = INT_EN ? {1'b0, 16'h0023} : 17'h0;
        n_compared++;
        if (obs_reg !== want_reg) begin
            n_mismatch++; $display("[TB] FAIL int_active_clear: got %h want %h", obs_reg, want_reg);
        end
        want = INT_EN ? word(1, VEC, 2'b00, 1, 0) : 21'h0;
        n_compared++;
        if (obs_comb !== want) begin
            n_mismatch++; $display("[TB] FAIL int_reentry: got %h want %h", obs_comb, want);
        end
        clear_stim(); s_ret = 1; step();
        want = INT_EN ? word(1, 16'h0031, 2'b00, 1, 0) : 21'h0;
        n_compared++;
        if (obs_comb !== want) begin
            n_mismatch++; $display("[TB] FAIL int_return2: got %h want %h", obs_comb, want);
        end
        clear_stim(); step();
    endtask

    task automatic test_deferred_irq();
        logic [20:0] want;
        clear_stim();
        s_hold = 1; step();
        s_hold = 0; s_irq = 1; s_pc = 16'h0066;
        for (int i = 0; i < 2; i++) begin
            step();
            want = word(0, 16'h0, 2'b01, 0, 0);
            n_compared++;
            if (obs_comb !== want) begin
                n_mismatch++; $display("[TB] FAIL defer_wait%0d: got %h want %h", i, obs_comb, want);
            end
        end
        s_res = 1; s_jmp = 0; s_jpc = 16'h0222; step();
        n_compared++;
        if (obs_comb !== 21'h0) begin
            n_mismatch++; $display("[TB] FAIL defer_resolve: got %h want %h", obs_comb, 21'h0);
        end
        s_res = 0; s_pc = 16'h0077; step();
        want = INT_EN ? word(1, VEC, 2'b00, 1, 0) : 21'h0;
        n_compared++;
        if (obs_comb !== want) begin
            n_mismatch++; $display("[TB] FAIL defer_entry: got %h want %h", obs_comb, want);
        end
        clear_stim(); s_ret = 1; step();
        want = INT_EN ? word(1, 16'h0077, 2'b00, 1, 0) : 21'h0;
        n_compared++;
        if (obs_comb !== want) begin
            n_mismatch++; $display("[TB] FAIL defer_return: got %h want %h", obs_comb, want);
        end
        clear_stim(); step();
    endtask

    task automatic test_reset_mid_isr();
        logic [16:0] want_reg;
        clear_stim();
        s_irq = 1; s_pc = 16'h0123; step();
        clear_stim(); step();
        want_reg = INT_EN ? {1'b1, 16'h0123} : 17'h0;
        n_compared++;
        if (obs_reg !== want_reg) begin
            n_mismatch++; $display("[TB] FAIL midisr_inside: got %h want %h", obs_reg, want_reg);
        end
        s_rst_n = 0; s_hold = 1; s_irq = 1; step();
        n_compared++;
        if (obs_comb !== 21'h0) begin
            n_mismatch++; $display("[TB] FAIL midisr_reset_comb: got %h want %h", obs_comb, 21'h0);
        end
        s_rst_n = 1; step();
        n_compared++;
        if (obs_reg !== 17'h0) begin
            n_mismatch++; $display("[TB] FAIL midisr_reg_cleared: got %h want %h", obs_reg, 17'h0);
        end
        n_compared++;
        if (obs_comb !== 21'h0) begin
            n_mismatch++; $display("[TB] FAIL midisr_after_comb: got %h want %h", obs_comb, 21'h0);
        end
        clear_stim(); step();
    endtask

    task automatic test_random();
        clear_stim();
        for (int i = 0; i < 600; i++) begin
            s_rst_n = ($urandom_range(0, 99) != 0);
            s_hold  = ($urandom_range(0, 3) == 0);
            s_res   = ($urandom_range(0, 2) == 0);
            s_jmp   = $urandom_range(0, 1);
            s_haz   = ($urandom_range(0, 7) == 0);
            s_irq   = ($urandom_range(0, 3) == 0);
            s_ret   = ($urandom_range(0, 5) == 0);
            s_pc    = 16'($urandom);
            s_jpc   = 16'($urandom);
            step();
            n_compared++;
            if (obs_comb !== e_comb) begin
                n_mismatch++; $display("[TB] FAIL rand_comb[%0d]: got %h want %h", i, obs_comb, e_comb);
            end
            n_compared++;
            if (obs_reg !== {m_isr, m_epc}) begin
                n_mismatch++; $display("[TB] FAIL rand_reg[%0d]: got %h want %h", i, obs_reg, {m_isr, m_epc});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_branch(1'b1);
        test_branch(1'b0);
        test_timeout();
        test_load_hazard();
        test_interrupt();
        test_deferred_irq();
        test_reset_mid_isr();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
